// File: rtl/axi_lite_wr_mux.sv
// Three-master to one-slave AXI4-Lite write-channel mux that holds one arbiter grant per AW/W/B transaction.
// Optional WR_MUX_TIMEOUT_EN: a stalled B channel gets a local SLVERR response, and late B responses are drained in IDLE.
module axi_lite_wr_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3*ADDR_W-1:0]       m_awaddr,
  input  logic [2:0]                m_awvalid,
  output logic [2:0]                m_awready,
  input  logic [3*DATA_W-1:0]       m_wdata,
  input  logic [3*(DATA_W/8)-1:0]   m_wstrb,
  input  logic [2:0]                m_wvalid,
  output logic [2:0]                m_wready,
  output logic [5:0]                m_bresp,
  output logic [2:0]                m_bvalid,
  input  logic [2:0]                m_bready,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic [1:0]                s_bresp,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic [2:0]                arb_req,
  input  logic [2:0]                arb_grant,
  output logic                      busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        out_en_q;

  logic [2:0]        sel_oh;
  logic [ADDR_W-1:0] sel_awaddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_awvalid, sel_wvalid, sel_bready;
  logic              gnt_ok;
  logic [1:0]        gnt_idx;
  logic [1:0]        resp_val;

`ifdef WR_MUX_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timed_out;
`endif

  // Selected-master views of the request channels.
  always_comb begin
    sel_oh = 3'b001 << sel_q;
    case (sel_q)
      2'd1: begin
        sel_awaddr = m_awaddr[ADDR_W +: ADDR_W];
        sel_wdata  = m_wdata[DATA_W +: DATA_W];
        sel_wstrb  = m_wstrb[STRB_W +: STRB_W];
      end
      2'd2: begin
        sel_awaddr = m_awaddr[2*ADDR_W +: ADDR_W];
        sel_wdata  = m_wdata[2*DATA_W +: DATA_W];
        sel_wstrb  = m_wstrb[2*STRB_W +: STRB_W];
      end
      default: begin
        sel_awaddr = m_awaddr[0 +: ADDR_W];
        sel_wdata  = m_wdata[0 +: DATA_W];
        sel_wstrb  = m_wstrb[0 +: STRB_W];
      end
    endcase
    sel_awvalid = |(m_awvalid & sel_oh);
    sel_wvalid  = |(m_wvalid & sel_oh);
    sel_bready  = |(m_bready & sel_oh);
  end

  always_comb begin
    gnt_ok  = 1'b1;
    gnt_idx = 2'd0;
    case (arb_grant)
      3'b001:  gnt_idx = 2'd0;
      3'b010:  gnt_idx = 2'd1;
      3'b100:  gnt_idx = 2'd2;
      default: gnt_ok  = 1'b0;
    endcase
  end

`ifdef WR_MUX_TIMEOUT_EN
  assign timed_out = (cnt_q == 8'hFF);
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    s_awaddr  = sel_awaddr;
    s_wdata   = sel_wdata;
    s_wstrb   = sel_wstrb;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    resp_val  = 2'b00;
    arb_req   = '0;
    busy      = (state_q != IDLE);
`ifdef WR_MUX_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // out_en_q keeps requests and grants masked until the first edge after reset release.
        arb_req = out_en_q ? m_awvalid : 3'b000;
`ifdef WR_MUX_TIMEOUT_EN
        s_bready = out_en_q;
`endif
        if (out_en_q && gnt_ok && |(m_awvalid & arb_grant)) begin
          sel_d   = gnt_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_awvalid = sel_awvalid;
        m_awready = s_awready ? sel_oh : 3'b000;
        if (sel_awvalid && s_awready) state_d = DATA;
      end
      DATA: begin
        s_wvalid = sel_wvalid;
        m_wready = s_wready ? sel_oh : 3'b000;
        if (sel_wvalid && s_wready) begin
          state_d = RESP;
`ifdef WR_MUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RESP: begin
`ifdef WR_MUX_TIMEOUT_EN
        if (timed_out) begin
          m_bvalid = sel_oh;
          resp_val = 2'b10;
          if (sel_bready) state_d = IDLE;
        end else begin
          m_bvalid = s_bvalid ? sel_oh : 3'b000;
          resp_val = s_bresp;
          s_bready = sel_bready;
          if (s_bvalid && sel_bready) state_d = IDLE;
          if (!s_bvalid) cnt_d = cnt_q + 8'd1;
        end
`else
        m_bvalid = s_bvalid ? sel_oh : 3'b000;
        resp_val = s_bresp;
        s_bready = sel_bready;
        if (s_bvalid && sel_bready) state_d = IDLE;
`endif
        for (int unsigned i = 0; i < 3; i++) begin
          if (sel_oh[i]) m_bresp[2*i +: 2] = resp_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      out_en_q <= 1'b1;
    end
  end

`ifdef WR_MUX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_axi_lite_wr_mux.sv
// Self-checking bench for axi_lite_wr_mux: grant-decode table, directed corner cases, and randomized transactions.
module tb_axi_lite_wr_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef WR_MUX_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3*AW-1:0] m_awaddr;
  logic [2:0]      m_awvalid, m_awready;
  logic [3*DW-1:0] m_wdata;
  logic [3*SW-1:0] m_wstrb;
  logic [2:0]      m_wvalid, m_wready;
  logic [5:0]      m_bresp;
  logic [2:0]      m_bvalid, m_bready;
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid, s_awready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_wvalid, s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid, s_bready;
  logic [2:0]      arb_req, arb_grant;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  axi_lite_wr_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .arb_req(arb_req), .arb_grant(arb_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; arb_grant = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
  endtask

  // Outputs that must all be zero during reset.
  function automatic logic [15:0] ctl_bundle();
    return {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, arb_req, busy};
  endfunction

  // One full transaction for master m. Slave readies are held low for ad/wd cycles
  // and bvalid for bd cycles; stage boundaries follow from those delays.
  task automatic do_txn(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] strb, input int ad, input int wd, input int bd,
                        input logic [1:0] br, input bit contend);
    logic [2:0]  oh;
    logic [2:0]  awv;
    logic [1:0]  rsp;
    logic [12:0] exp_b, act_b;
    int          last, stage;
    oh   = 3'b001 << m;
    last = 3 + ad + wd + bd;
    for (int c = 0; c <= last; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (i == m) begin
          m_awaddr[i*AW +: AW] = addr;
          m_wdata[i*DW +: DW]  = data;
          m_wstrb[i*SW +: SW]  = strb;
        end else begin
          m_awaddr[i*AW +: AW] = $urandom;
          m_wdata[i*DW +: DW]  = $urandom;
          m_wstrb[i*SW +: SW]  = SW'($urandom);
        end
      end
      awv       = contend ? ~oh : (3'($urandom) & ~oh);
      awv[m]    = (c <= 1 + ad);
      m_awvalid = awv;
      m_wvalid  = 3'($urandom) & ~oh;
      m_wvalid[m] = (c <= 2 + ad + wd);
      m_bready  = 3'($urandom) | oh;
      arb_grant = (c == 0) ? oh : 3'($urandom);
      s_awready = (c == 1 + ad);
      s_wready  = (c == 2 + ad + wd);
      s_bvalid  = (c == last);
      rsp       = (c == last) ? br : 2'($urandom);
      s_bresp   = rsp;
      #1;
      if (c == 0)               stage = 0;
      else if (c <= 1 + ad)     stage = 1;
      else if (c <= 2 + ad + wd) stage = 2;
      else                      stage = 3;
      exp_b = {stage == 1, stage == 2, (stage == 3) || (stage == 0 && TO),
               (c == 1 + ad) ? oh : 3'b000,
               (c == 2 + ad + wd) ? oh : 3'b000,
               (c == last) ? oh : 3'b000,
               stage != 0};
      act_b = {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, busy};
      check($sformatf("txn_m%0d_c%0d_ctl", m, c), 64'(act_b), 64'(exp_b));
      if (stage == 0) check("txn_arb_req", 64'(arb_req), 64'(awv));
      if (stage == 1) check("txn_awaddr", 64'(s_awaddr), 64'(addr));
      if (stage == 2) check("txn_wdata", 64'({s_wstrb, s_wdata}), 64'({strb, data}));
      if (stage == 3) check("txn_bresp", 64'(m_bresp), 64'(6'(rsp) << (2 * m)));
      step();
    end
    clear_inputs();
    #1;
    check("txn_post_busy", 64'(busy), 64'd0);
  endtask

  typedef struct packed {
    logic [2:0] awv;
    logic [2:0] gnt;
    logic       go;
  } vec_t;

  vec_t tbl[8];
  int   k;

  initial begin
    tbl[0] = '{awv: 3'b000, gnt: 3'b001, go: 1'b0};
    tbl[1] = '{awv: 3'b010, gnt: 3'b010, go: 1'b1};
    tbl[2] = '{awv: 3'b111, gnt: 3'b011, go: 1'b0};
    tbl[3] = '{awv: 3'b011, gnt: 3'b100, go: 1'b0};
    tbl[4] = '{awv: 3'b100, gnt: 3'b100, go: 1'b1};
    tbl[5] = '{awv: 3'b001, gnt: 3'b001, go: 1'b1};
    tbl[6] = '{awv: 3'b111, gnt: 3'b000, go: 1'b0};
    tbl[7] = '{awv: 3'b111, gnt: 3'b111, go: 1'b0};

    m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    clear_inputs();

    // Reset: outputs held low even with requests pending, until the first edge after release.
    rst_n     = 1'b0;
    m_awvalid = 3'b111;
    #23;
    check("reset_outputs", 64'(ctl_bundle()), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_release_arb_req", 64'(arb_req), 64'd0);
    step();
    check("reset_first_edge_arb_req", 64'(arb_req), 64'h7);
    check("reset_busy", 64'(busy), 64'd0);
    clear_inputs();
    step();

    // Grant decode table, applied from IDLE.
    for (int t = 0; t < 8; t++) begin
      m_awvalid = tbl[t].awv;
      m_wvalid  = tbl[t].awv;
      arb_grant = tbl[t].gnt;
      #1;
      check($sformatf("tbl%0d_arb_req", t), 64'(arb_req), 64'(tbl[t].awv));
      step();
      check($sformatf("tbl%0d_busy", t), 64'(busy), 64'(tbl[t].go));
      arb_grant = '0;
      if (tbl[t].go) begin
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = 3'b111;
        k = 0;
        while (busy && k < 6) begin
          step();
          k++;
        end
        check($sformatf("tbl%0d_drain", t), 64'(busy), 64'd0);
      end
      clear_inputs();
      step();
    end

    // Single write, minimum length; then backpressure with SLVERR forwarded.
    do_txn(1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    do_txn(2, 32'h2000_0040, 32'h1234_5678, 4'h5, 3, 2, 5, 2'b10, 1'b0);

    // Contention with the arbiter rotating.
    do_txn(0, 32'h100, 32'h0000_0001, 4'h1, 0, 1, 0, 2'b00, 1'b1);
    do_txn(1, 32'h200, 32'h0000_0002, 4'h3, 1, 0, 1, 2'b01, 1'b1);
    do_txn(2, 32'h300, 32'h0000_0003, 4'hC, 0, 0, 2, 2'b11, 1'b1);

    for (int r = 0; r < 40; r++) begin
      do_txn(int'($urandom_range(0, 2)), $urandom, $urandom, SW'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             2'($urandom), 1'($urandom));
    end

    // Reset asserted mid-DATA drops every valid/ready at once.
    m_awvalid = 3'b001; m_wvalid = 3'b001; arb_grant = 3'b001; s_awready = 1'b1;
    step();
    arb_grant = '0;
    step();
    #1;
    check("middata_wvalid", 64'(s_wvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("middata_reset_outputs", 64'(ctl_bundle()), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("middata_release_arb_req", 64'(arb_req), 64'd0);
    step();
    check("middata_idle_arb_req", 64'(arb_req), 64'h1);
    check("middata_idle_busy", 64'(busy), 64'd0);
    clear_inputs();
    step();

`ifdef WR_MUX_TIMEOUT_EN
    // Slave never responds: local SLVERR on the 256th RESP cycle, then a late bvalid is drained.
    m_awvalid = 3'b001; m_wvalid = 3'b001; arb_grant = 3'b001;
    s_awready = 1'b1; s_wready = 1'b1;
    step();
    arb_grant = '0;
    step();
    m_awvalid = '0;
    step();
    m_wvalid = '0;
    #1;
    k = 1;
    while (!m_bvalid[0] && k < 400) begin
      step();
      k++;
    end
    check("timeout_cycles", 64'(k), 64'd256);
    check("timeout_bresp", 64'(m_bresp), 64'h2);
    check("timeout_s_bready", 64'(s_bready), 64'd0);
    m_bready = 3'b001;
    step();
    check("timeout_busy", 64'(busy), 64'd0);
    s_bvalid = 1'b1;
    #1;
    check("timeout_drain", 64'(s_bready), 64'd1);
    clear_inputs();
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
